// File: rtl/v_residual_pkg.sv
// rtl/v_residual_pkg.sv - shared types, digit encodings and digit selection for the residual engine
//
// Contents:
//   state_e        FSM state encoding (IDLE, CHUNK, SELECT)
//   DIG_POS/NEG/ZERO  signed-digit rail encodings {plus,minus}
//   select_digit() maps the signed top bits of the residual estimate to a digit
package v_residual_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHUNK  = 2'd1,
    ST_SELECT = 2'd2
  } state_e;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  // est_top is the sign-extended top slice of the estimate.
  // >= 1 selects +1, {0,-1} select 0, <= -2 selects -1.
  function automatic logic [1:0] select_digit(input logic signed [7:0] est_top);
    if (est_top >= 8'sh01) begin
      return DIG_POS;
    end else if (est_top >= 8'shFF) begin
      return DIG_ZERO;
    end else begin
      return DIG_NEG;
    end
  endfunction

endpackage

// File: rtl/v_residual_engine_if.sv
// rtl/v_residual_engine_if.sv - operand/result bus between the residual engine and its operand store
//
// Signals:
//   start, flush, x_digit                  control and input digit
//   rd_addr                                chunk index requested by the engine
//   q/w_plus/minus_chunk, w_plus/minus_int operand chunks and integer parts at rd_addr
//   v_plus/minus_chunk, v_chunk_valid      result chunk stream
//   v_int_plus/minus, q_digit, q_valid     per-iteration results
//   busy                                   engine not idle
// Modports: master = engine side, slave = operand store / controller side.
interface v_residual_engine_if #(
  parameter int CHUNK_W = 64,
  parameter int UPPER_W = 5,
  parameter int ADDR_W  = 7
);
  logic               start;
  logic               flush;
  logic [1:0]         x_digit;
  logic [CHUNK_W-1:0] q_plus_chunk;
  logic [CHUNK_W-1:0] q_minus_chunk;
  logic [CHUNK_W-1:0] w_plus_chunk;
  logic [CHUNK_W-1:0] w_minus_chunk;
  logic [UPPER_W-1:0] w_plus_int;
  logic [UPPER_W-1:0] w_minus_int;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CHUNK_W-1:0] v_plus_chunk;
  logic [CHUNK_W-1:0] v_minus_chunk;
  logic               v_chunk_valid;
  logic [UPPER_W-1:0] v_int_plus;
  logic [UPPER_W-1:0] v_int_minus;
  logic [1:0]         q_digit;
  logic               q_valid;
  logic               busy;

  modport master (
    input  start, flush, x_digit,
    input  q_plus_chunk, q_minus_chunk, w_plus_chunk, w_minus_chunk,
    input  w_plus_int, w_minus_int,
    output rd_addr, v_plus_chunk, v_minus_chunk, v_chunk_valid,
    output v_int_plus, v_int_minus, q_digit, q_valid, busy
  );

  modport slave (
    output start, flush, x_digit,
    output q_plus_chunk, q_minus_chunk, w_plus_chunk, w_minus_chunk,
    output w_plus_int, w_minus_int,
    input  rd_addr, v_plus_chunk, v_minus_chunk, v_chunk_valid,
    input  v_int_plus, v_int_minus, q_digit, q_valid, busy
  );

endinterface

// File: rtl/rail_chunk_adder.sv
// rtl/rail_chunk_adder.sv - two independent CHUNK_W binary adders (plus and minus rails)
//
// Ports:
//   a_plus, b_plus, cin_plus    -> sum_plus, cout_plus    plus-rail add
//   a_minus, b_minus, cin_minus -> sum_minus, cout_minus  minus-rail add
module rail_chunk_adder #(
  parameter int CHUNK_W = 64
) (
  input  logic [CHUNK_W-1:0] a_plus,
  input  logic [CHUNK_W-1:0] b_plus,
  input  logic               cin_plus,
  input  logic [CHUNK_W-1:0] a_minus,
  input  logic [CHUNK_W-1:0] b_minus,
  input  logic               cin_minus,
  output logic [CHUNK_W-1:0] sum_plus,
  output logic               cout_plus,
  output logic [CHUNK_W-1:0] sum_minus,
  output logic               cout_minus
);

  assign {cout_plus, sum_plus} = {1'b0, a_plus} + {1'b0, b_plus}
                               + {{CHUNK_W{1'b0}}, cin_plus};

  assign {cout_minus, sum_minus} = {1'b0, a_minus} + {1'b0, b_minus}
                                 + {{CHUNK_W{1'b0}}, cin_minus};

endmodule

// File: rtl/v_residual_engine.sv
// rtl/v_residual_engine.sv - chunk-serial redundant residual update with quotient digit selection
//
// Ports:
//   clk         rising-edge clock
//   asyn_reset  asynchronous active-high reset
//   bus         v_residual_engine_if.master: control, operand chunks at rd_addr,
//               result chunk stream, registered integer parts, q_digit/q_valid, busy
// One iteration: start -> NUM_CHUNKS CHUNK cycles (LSB chunk first) -> one SELECT cycle.
module v_residual_engine
  import v_residual_pkg::*;
#(
  parameter int CHUNK_W    = 64,
  parameter int NUM_CHUNKS = 4,
  parameter int UPPER_W    = 5,
  parameter int SEL_BITS   = 4,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  v_residual_engine_if.master   bus
);

  localparam logic [1:0]        S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0]        S_CHUNK  = 2'(ST_CHUNK);
  localparam logic [1:0]        S_SELECT = 2'(ST_SELECT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHUNKS - 1);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  addr;
  logic               cin_plus;
  logic               cin_minus;
  logic               cmp;
  logic [UPPER_W-1:0] v_int_plus_r;
  logic [UPPER_W-1:0] v_int_minus_r;
  logic [1:0]         q_digit_r;

  logic [CHUNK_W-1:0] sum_plus;
  logic [CHUNK_W-1:0] sum_minus;
  logic               cout_plus;
  logic               cout_minus;

  rail_chunk_adder #(.CHUNK_W(CHUNK_W)) u_adder (
    .a_plus    (bus.w_plus_chunk),
    .b_plus    (bus.q_plus_chunk),
    .cin_plus  (cin_plus),
    .a_minus   (bus.w_minus_chunk),
    .b_minus   (bus.q_minus_chunk),
    .cin_minus (cin_minus),
    .sum_plus  (sum_plus),
    .cout_plus (cout_plus),
    .sum_minus (sum_minus),
    .cout_minus(cout_minus)
  );

  logic in_chunk;
  logic in_select;
  logic last_chunk;

  assign in_chunk   = (state == S_CHUNK);
  assign in_select  = (state == S_SELECT);
  assign last_chunk = (addr == LAST_ADDR);

  // On the top chunk the carry-out and the chunk MSB form a 2-bit value that
  // absorbs the input digit; its upper two bits spill into the integer part.
  logic [2:0]         fold_plus;
  logic [2:0]         fold_minus;
  logic [1:0]         shift_plus;
  logic [1:0]         shift_minus;
  logic [CHUNK_W-1:0] v_plus_now;
  logic [CHUNK_W-1:0] v_minus_now;

  assign fold_plus  = {1'b0, cout_plus,  sum_plus[CHUNK_W-1]}  + {2'b00, bus.x_digit[1]};
  assign fold_minus = {1'b0, cout_minus, sum_minus[CHUNK_W-1]} + {2'b00, bus.x_digit[0]};

  assign shift_plus  = last_chunk ? fold_plus[2:1]  : 2'b00;
  assign shift_minus = last_chunk ? fold_minus[2:1] : 2'b00;

  assign v_plus_now  = last_chunk ? {fold_plus[0],  sum_plus[CHUNK_W-2:0]}  : sum_plus;
  assign v_minus_now = last_chunk ? {fold_minus[0], sum_minus[CHUNK_W-2:0]} : sum_minus;

  // Chunks arrive LSB first, so a later (more significant) strict difference
  // overrides, and equality keeps the verdict from lower chunks.
  logic cmp_next;
  assign cmp_next = (v_plus_now > v_minus_now) | ((v_plus_now == v_minus_now) & cmp);

  // Estimate of v = v_plus - v_minus; (cmp - 1) borrows one when the fraction
  // rails make v_plus < v_minus.
  logic [UPPER_W-1:0]  est;
  logic [SEL_BITS-1:0] est_top;
  logic signed [7:0]   est_ext;
  logic [1:0]          sel_digit;

  assign est       = v_int_plus_r - v_int_minus_r + UPPER_W'(cmp) - UPPER_W'(1);
  assign est_top   = est[UPPER_W-1 -: SEL_BITS];
  assign est_ext   = {{(8 - SEL_BITS){est_top[SEL_BITS-1]}}, est_top};
  assign sel_digit = select_digit(est_ext);

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      cin_plus      <= 1'b0;
      cin_minus     <= 1'b0;
      cmp           <= 1'b1;
      v_int_plus_r  <= '0;
      v_int_minus_r <= '0;
      q_digit_r     <= DIG_ZERO;
    end else if (bus.flush) begin
      state     <= S_IDLE;
      addr      <= '0;
      cin_plus  <= 1'b0;
      cin_minus <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_CHUNK;
            addr      <= '0;
            cin_plus  <= 1'b0;
            cin_minus <= 1'b0;
            cmp       <= 1'b1;
          end
        end
        S_CHUNK: begin
          cin_plus  <= cout_plus;
          cin_minus <= cout_minus;
          cmp       <= cmp_next;
          if (last_chunk) begin
            state         <= S_SELECT;
            addr          <= '0;
            v_int_plus_r  <= bus.w_plus_int  + UPPER_W'(shift_plus);
            v_int_minus_r <= bus.w_minus_int + UPPER_W'(shift_minus);
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        S_SELECT: begin
          q_digit_r <= sel_digit;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush landing in the SELECT cycle suppresses that iteration's result.
  logic q_valid_now;
  assign q_valid_now = in_select & ~bus.flush;

  assign bus.rd_addr       = addr;
  assign bus.v_plus_chunk  = in_chunk ? v_plus_now  : '0;
  assign bus.v_minus_chunk = in_chunk ? v_minus_now : '0;
  assign bus.v_chunk_valid = in_chunk;
  assign bus.v_int_plus    = v_int_plus_r;
  assign bus.v_int_minus   = v_int_minus_r;
  assign bus.q_valid       = q_valid_now;
  assign bus.q_digit       = q_valid_now ? sel_digit : q_digit_r;
  assign bus.busy          = (state != S_IDLE);

endmodule

// File: tb/tb_v_residual_engine.sv
// tb/tb_v_residual_engine.sv - directed table-driven bench for v_residual_engine
module tb_v_residual_engine;
  import v_residual_pkg::*;

  localparam int CW = 8;
  localparam int NC = 4;
  localparam int UW = 5;
  localparam int SB = 4;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic asyn_reset;
  always #5 clk = ~clk;

  v_residual_engine_if #(.CHUNK_W(CW), .UPPER_W(UW), .ADDR_W(AW)) bus ();

  v_residual_engine #(
    .CHUNK_W(CW), .NUM_CHUNKS(NC), .UPPER_W(UW), .SEL_BITS(SB), .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .asyn_reset(asyn_reset),
    .bus       (bus)
  );

  // Operand store: packed {chunk3,chunk2,chunk1,chunk0}, read at rd_addr.
  logic [31:0] op_wp, op_qp, op_wm, op_qm;
  logic [1:0]  idx;
  assign idx = bus.rd_addr[1:0];
  assign bus.w_plus_chunk  = op_wp[idx*8 +: 8];
  assign bus.q_plus_chunk  = op_qp[idx*8 +: 8];
  assign bus.w_minus_chunk = op_wm[idx*8 +: 8];
  assign bus.q_minus_chunk = op_qm[idx*8 +: 8];

  typedef struct {
    logic [31:0] wp, qp, wm, qm;
    logic [4:0]  wpi, wmi;
    logic [1:0]  x;
    logic [31:0] evp, evm;
    logic [4:0]  evip, evim;
    logic [1:0]  eq;
  } vec_t;

  vec_t vecs[13];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [31:0] wp, qp, wm, qm, input logic [4:0] wpi, wmi,
                              input logic [1:0] x, input logic [31:0] evp, evm,
                              input logic [4:0] evip, evim, input logic [1:0] eq);
    vec_t v;
    v.wp = wp; v.qp = qp; v.wm = wm; v.qm = qm; v.wpi = wpi; v.wmi = wmi; v.x = x;
    v.evp = evp; v.evm = evm; v.evip = evip; v.evim = evim; v.eq = eq;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    op_wp = v.wp; op_qp = v.qp; op_wm = v.wm; op_qm = v.qm;
    bus.w_plus_int = v.wpi; bus.w_minus_int = v.wmi; bus.x_digit = v.x;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    @(negedge clk);
    load(v);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("v%0d_valid%0d", id, i), 64'(bus.v_chunk_valid), 64'd1);
      check($sformatf("v%0d_addr%0d", id, i), 64'(bus.rd_addr), 64'(i));
      check($sformatf("v%0d_vp%0d", id, i), 64'(bus.v_plus_chunk), 64'(v.evp[i*8 +: 8]));
      check($sformatf("v%0d_vm%0d", id, i), 64'(bus.v_minus_chunk), 64'(v.evm[i*8 +: 8]));
    end
    @(negedge clk);
    check($sformatf("v%0d_qvalid", id), 64'(bus.q_valid), 64'd1);
    check($sformatf("v%0d_cvalid_sel", id), 64'(bus.v_chunk_valid), 64'd0);
    check($sformatf("v%0d_vp_sel", id), 64'(bus.v_plus_chunk), 64'd0);
    check($sformatf("v%0d_qdigit", id), 64'(bus.q_digit), 64'(v.eq));
    check($sformatf("v%0d_vip", id), 64'(bus.v_int_plus), 64'(v.evip));
    check($sformatf("v%0d_vim", id), 64'(bus.v_int_minus), 64'(v.evim));
    @(negedge clk);
    check($sformatf("v%0d_qvalid_end", id), 64'(bus.q_valid), 64'd0);
    check($sformatf("v%0d_busy_end", id), 64'(bus.busy), 64'd0);
    check($sformatf("v%0d_qdigit_hold", id), 64'(bus.q_digit), 64'(v.eq));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   64'(bus.busy), 64'd0);
    check({tag, "_addr"},   64'(bus.rd_addr), 64'd0);
    check({tag, "_qvalid"}, 64'(bus.q_valid), 64'd0);
    check({tag, "_qdigit"}, 64'(bus.q_digit), 64'(DIG_ZERO));
    check({tag, "_vip"},    64'(bus.v_int_plus), 64'd0);
    check({tag, "_vim"},    64'(bus.v_int_minus), 64'd0);
    check({tag, "_cvalid"}, 64'(bus.v_chunk_valid), 64'd0);
    check({tag, "_vp"},     64'(bus.v_plus_chunk), 64'd0);
  endtask

  int qv_count;

  initial begin
    vecs[0]  = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, DIG_ZERO);
    vecs[1]  = mk(32'h000000FF, 32'h00000001, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00,
                  32'h00000100, 32'h0, 5'd0, 5'd0, DIG_ZERO);
    vecs[2]  = mk(32'hFF000000, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 2'b10,
                  32'h7F000000, 32'h0, 5'd3, 5'd0, DIG_POS);
    vecs[3]  = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd6, 2'b00, 32'h0, 32'h0, 5'd0, 5'd6, DIG_NEG);
    vecs[4]  = mk(32'h0, 32'h0, 32'h00050000, 32'h0, 5'd0, 5'd0, 2'b00,
                  32'h0, 32'h00050000, 5'd0, 5'd0, DIG_ZERO);
    vecs[5]  = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 2'b00, 32'h0, 32'h0, 5'd2, 5'd0, DIG_POS);
    vecs[6]  = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 2'b00, 32'h0, 32'h0, 5'd1, 5'd0, DIG_ZERO);
    vecs[7]  = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd2, 2'b00, 32'h0, 32'h0, 5'd0, 5'd2, DIG_ZERO);
    vecs[8]  = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, DIG_NEG);
    vecs[9]  = mk(32'hFF000000, 32'h01000000, 32'h0, 32'h0, 5'd31, 5'd0, 2'b10,
                  32'h80000000, 32'h0, 5'd0, 5'd0, DIG_ZERO);
    vecs[10] = mk(32'h0, 32'h0, 32'h80000000, 32'h0, 5'd0, 5'd0, 2'b01,
                  32'h0, 32'h0, 5'd0, 5'd1, DIG_ZERO);
    vecs[11] = mk(32'h00FFFFFF, 32'h00000001, 32'h00000100, 32'h00000203, 5'd0, 5'd0, 2'b00,
                  32'h01000000, 32'h00000303, 5'd0, 5'd0, DIG_ZERO);
    vecs[12] = mk(32'hFF000000, 32'hFF000000, 32'h0, 32'h0, 5'd0, 5'd0, 2'b10,
                  32'h7E000000, 32'h0, 5'd2, 5'd0, DIG_POS);

    asyn_reset = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    load(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    asyn_reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    for (int v = 0; v < 13; v++) begin
      run_vec(vecs[v], v);
    end

    // Flush at chunk 2: v_int_* and q_digit keep the vecs[12] results.
    @(negedge clk);
    load(vecs[3]);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush_at_addr2", 64'(bus.rd_addr), 64'd2);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_qvalid", 64'(bus.q_valid), 64'd0);
    check("flush_vip_held", 64'(bus.v_int_plus), 64'd2);
    check("flush_vim_held", 64'(bus.v_int_minus), 64'd0);
    check("flush_qdigit_held", 64'(bus.q_digit), 64'(DIG_POS));
    qv_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.q_valid) qv_count++;
    end
    check("flush_no_qvalid", 64'(qv_count), 64'd0);
    run_vec(vecs[3], 103);

    // Asynchronous reset at chunk 1.
    @(negedge clk);
    load(vecs[2]);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_at_addr1", 64'(bus.rd_addr), 64'd1);
    asyn_reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    asyn_reset = 1'b0;
    qv_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.q_valid) qv_count++;
    end
    check("rst_no_qvalid", 64'(qv_count), 64'd0);
    check("rst_busy_after", 64'(bus.busy), 64'd0);

    // start held while busy must not launch a second iteration.
    load(vecs[2]);
    bus.start = 1'b1;
    @(posedge clk);
    qv_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.q_valid) begin
        qv_count++;
        check("busy_start_qdigit", 64'(bus.q_digit), 64'(DIG_POS));
        check("busy_start_vip", 64'(bus.v_int_plus), 64'd3);
      end
      if (i == 4) bus.start = 1'b0;
    end
    check("busy_start_one_qvalid", 64'(qv_count), 64'd1);
    check("busy_start_idle", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_residual_engine.md
V_RESIDUAL_ENGINE -- requirements
Module: v_residual_engine

Interface
REQ-001 Parameter CHUNK_W, 64, bit width of one fractional residual chunk per rail.
REQ-002 Parameter NUM_CHUNKS, 4, fractional chunks per iteration; must be at least 2.
REQ-003 Parameter UPPER_W, 5, integer-part width per rail.
REQ-004 Parameter SEL_BITS, 4, MSBs of the integer estimate used for digit selection; must not exceed UPPER_W.
REQ-005 Parameter ADDR_W, 7, chunk address width; must satisfy 2^ADDR_W >= NUM_CHUNKS.
REQ-006 Reset is asyn_reset, asynchronous, active-high; the clock is clk.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 asyn_reset  in  1  asynchronous active-high reset.
REQ-009 start  in  1  begin one digit iteration; sampled only in IDLE.
REQ-010 flush  in  1  synchronous abort to IDLE; takes priority over start.
REQ-011 x_digit  in  2  signed input digit as {plus,minus} rail bits.
REQ-012 q_plus_chunk, q_minus_chunk, w_plus_chunk, w_minus_chunk  in  CHUNK_W each  operand chunk at rd_addr, valid combinationally in the same cycle.
REQ-013 w_plus_int, w_minus_int  in  UPPER_W each  integer parts of w.
REQ-014 rd_addr  out  ADDR_W  chunk index being processed; 0 is the least significant chunk.
REQ-015 v_plus_chunk, v_minus_chunk  out  CHUNK_W each  result chunk at rd_addr.
REQ-016 v_chunk_valid  out  1  result chunk valid this cycle.
REQ-017 v_int_plus, v_int_minus  out  UPPER_W each  registered integer parts of v.
REQ-018 q_digit  out  2  selected quotient digit: 10 = +1, 01 = -1, 00 = 0.
REQ-019 q_valid  out  1  one-cycle pulse qualifying q_digit and v_int_*.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM states shall be IDLE, CHUNK, and SELECT.
REQ-022 IDLE with start=1 shall transition to CHUNK and clear rd_addr to 0, both rail carries to 0, and cmp to 1.
REQ-023 In CHUNK, each rail shall independently binary-add its chunks as v_plus = w_plus + q_plus + cin_plus and v_minus = w_minus + q_minus + cin_minus, and shall register each rail's carry-out for the next chunk.
REQ-024 In CHUNK, v_chunk_valid shall be 1, and cmp shall update to (v_plus_chunk > v_minus_chunk) OR (equal AND cmp), where the comparison is unsigned.
REQ-025 In CHUNK, rd_addr shall increment each cycle; at rd_addr = NUM_CHUNKS-1 the FSM shall go to SELECT.
REQ-026 On the last chunk only, the result shall be formed as {shift_r, v_r[CHUNK_W-1]} = {cout_r, sum_r[CHUNK_W-1]} + x_digit rail bit, with 2-bit shift_r per rail; shift_r shall be 0 on every other chunk.
REQ-027 On the last chunk, v_int_plus shall be registered as (w_plus_int + shift_plus) mod 2^UPPER_W, and v_int_minus likewise.
REQ-028 In SELECT, est = v_int_plus - v_int_minus + cmp - 1 shall be computed mod 2^UPPER_W, and its top SEL_BITS bits, taken as signed, shall select the digit: >= 1 gives +1; 0 or -1 gives 0; <= -2 gives -1.
REQ-029 In SELECT, q_valid shall be 1 for exactly one cycle, after which the FSM shall return to IDLE.
REQ-030 If start is asserted at edge k, chunk i shall be processed in cycle k+1+i and q_valid shall be high in cycle k+1+NUM_CHUNKS.
REQ-031 start while busy shall be ignored.
REQ-032 flush shall force IDLE at the next edge, with no q_valid, carries cleared, and v_int_* held.
REQ-033 Outside CHUNK, v_chunk_valid shall be 0 and v_*_chunk shall be 0.
REQ-034 q_digit shall hold its last value between q_valid pulses.

Reset
REQ-035 Asserting asyn_reset shall force IDLE, rd_addr=0, carries=0, cmp=1, v_int_*=0, q_digit=00, q_valid=0, busy=0.
REQ-036 Reset asserted mid-iteration shall abort that iteration, with no q_valid pulse following deassertion.

Structure
REQ-037 Package v_residual_pkg shall hold the state enum, digit encodings (DIG_POS=10, DIG_NEG=01, DIG_ZERO=00), and the selection-threshold function.
REQ-038 Sub-module rail_chunk_adder shall implement the two independent CHUNK_W adders with carry-in and carry-out, parameterised on CHUNK_W.

Verification
REQ-039 With CHUNK_W=8, NUM_CHUNKS=4, UPPER_W=5: all-zero operands, x_digit=00, start -> chunks all 0, cmp=1, est=0, q_digit=00, q_valid at cycle k+5.
REQ-040 w_plus chunk0=FF, q_plus chunk0=01, other chunks 0 -> chunk0 v_plus=00, chunk1 v_plus=01 via carry, v_int_plus unchanged.
REQ-041 w_plus chunk3=FF, x_digit=10 -> shift_plus=1, and w_plus_int=00010 gives v_int_plus=00011, est=00011, top-4 bits 0001, q_digit=10.
REQ-042 w_minus_int=00110, all else 0, x_digit=00 -> est=11010, q_digit=01; with equal fraction rails, cmp=1.
REQ-043 flush asserted at chunk 2 -> no q_valid, busy drops next cycle, and a new start completes normally.
REQ-044 asyn_reset pulsed at chunk 1 -> all outputs at reset values; start pulsed during busy is ignored, giving exactly one q_valid.
